mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Multi-cycle multiply/divide sequencer for the pipelined MIPS core. It sits in the Execute stage, next to the ALU. It accepts MDU operations decoded by the control unit (MDUOp codes 1–8), runs mult/multu/div/divu over a fixed number of cycles, and owns the HI and LO registers. It also produces the Decode-stage stall that keeps any MDU instruction from entering Execute while an operation is still in flight.

## Interface
Parameters:
- MULT_CYCLES, default 5: Busy cycles for mult/multu (≥1).
- DIV_CYCLES, default 10: Busy cycles for div/divu (≥1).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on rising clk.
- Start  in  1  E-stage instruction is an MDU op (MDUOp != 0).
- MDUOp  in  4  E-stage op: 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 0 and 9–15 mean none.
- A  in  32  rs operand, already forwarded.
- B  in  32  rt operand, already forwarded.
- D_MDUOp  in  4  MDUOp of the instruction currently in Decode.
- Flush  in  1  E-stage instruction is a bubble; suppresses Start.
- Busy  out  1  multi-cycle operation in progress.
- Stall  out  1  freeze PC/F/D and insert a bubble into E.
- HI  out  32  HI register.
- LO  out  32  LO register.
- MDUOut  out  32  mfhi → HI, mflo → LO, otherwise 0 (combinational).

## Operation
- States: IDLE, RUN. Also holds a cycle counter cnt[7:0], pending results pHI/pLO, a pending-write flag, and the HI/LO registers.
- Effective start is go = Start & ~Flush & ~Busy & MDUOp in 1..4.
- On go:
  - Latch pHI/pLO from the computed result and load cnt with MULT_CYCLES or DIV_CYCLES.
  - Move to RUN.
- RUN: decrement cnt each cycle. When cnt reaches 1, write HI←pHI and LO←pLO, then return to IDLE.
- Busy = (state == RUN).
- mult: {HI,LO} = signed 64-bit A*B. multu: unsigned 64-bit product.
- div: LO = signed quotient truncated toward zero, HI = remainder with the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient and remainder.
- Divide by zero (B==0, div or divu): the op still runs for DIV_CYCLES, but HI and LO are left unchanged (pending-write flag cleared).
- mthi/mtlo (7/8) with Start & ~Flush & ~Busy: HI←A or LO←A at the next edge, single cycle, no Busy.
- mfhi/mflo: MDUOut reads HI/LO combinationally in the same cycle.
- Start with Busy=1 is ignored with no state change. Stall prevents this case; the bench must still check it.
- Stall = (D_MDUOp in 1..8) & (Busy | go).
  - Stall is combinational.
  - Non-MDU Decode instructions never stall on this block.
- Flush or an ignored Start never disturbs an operation already in flight.

## Timing
- Reset (reset_n=0 at an edge): state IDLE, cnt=0, HI=0, LO=0, pHI=pLO=0, Busy=0.
  - Stall and MDUOut follow their inputs with HI=LO=0.
  - Reset mid-RUN aborts the operation; HI/LO are not written.
- go in cycle t: Busy=1 in cycles t+1 … t+N, where N = MULT_CYCLES or DIV_CYCLES.
- The new HI/LO become visible in cycle t+N+1, the same cycle Busy falls.
- An MDU instruction in Decode during cycles t … t+N is stalled. It enters E at t+N+1 and mfhi there reads the new HI.
- A back-to-back go is allowed in cycle t+N+1; the earliest second result is visible at t+2N+2.
- mthi/mtlo in cycle t: the value is visible in HI/LO from t+1. An mfhi in E at t+1 reads it with no stall.
- Operands A/B are sampled only at go. Later changes do not affect the result.

## Test plan
- Reset, then mult A=0xFFFFFFFE (−2), B=3 with MULT_CYCLES=5 → Busy high cycles 1–5; at cycle 6 HI=0xFFFFFFFF, LO=0xFFFFFFFA and Busy=0.
- multu A=0xFFFFFFFF, B=2 → HI=0x00000001, LO=0xFFFFFFFE after 5 Busy cycles. div A=−7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 Busy cycles.
- div A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0. divu with B=0 after HI=0x11, LO=0x22 → HI/LO stay 0x11/0x22, and Busy is still 10 cycles.
- Stall: mult starts at t with D_MDUOp=5 → Stall=1 in t…t+5, 0 at t+6. With D_MDUOp=0 during Busy → Stall=0.
- mthi A=0xDEADBEEF, then mfhi next cycle → MDUOut=0xDEADBEEF with no stall. Start=1 with Flush=1 (mult) → Busy stays 0 and HI/LO unchanged.
- reset_n low at cycle 3 of a div → next cycle Busy=0 and HI=LO=0. Start (mult) while Busy → ignored, and the original result completes on schedule.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer for the E stage: owns HI/LO, runs
// mult/multu/div/divu over a fixed cycle count and raises the Decode stall.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        Start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  D_MDUOp,
    input  logic        Flush,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [7:0] MULT_N = 8'(MULT_CYCLES);
    localparam logic [7:0] DIV_N  = 8'(DIV_CYCLES);

    // Signed divide on magnitudes; the 0x80000000 / -1 overflow falls out as
    // quotient 0x80000000, remainder 0. Returns {remainder, quotient}.
    function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ua, ub, uq, ur, q, r;
        ua = a[31] ? (~a + 32'd1) : a;
        ub = b[31] ? (~b + 32'd1) : b;
        if (ub == 32'd0) begin
            uq = 32'd0;
            ur = 32'd0;
        end else begin
            uq = ua / ub;
            ur = ua % ub;
        end
        q = (a[31] ^ b[31]) ? (~uq + 32'd1) : uq;
        r = a[31] ? (~ur + 32'd1) : ur;
        return {r, q};
    endfunction

    function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    state_t             r_state;
    state_t             w_next_state;
    logic        [7:0]  r_cnt;
    logic        [31:0] r_phi;
    logic        [31:0] r_plo;
    logic               r_pwr;
    logic        [31:0] r_hi;
    logic        [31:0] r_lo;

    logic               w_arith;
    logic               w_is_div;
    logic               w_div0;
    logic               w_go;
    logic               w_mthi;
    logic               w_mtlo;
    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic        [63:0] w_result;

    assign w_arith  = (MDUOp >= OP_MULT) && (MDUOp <= OP_DIVU);
    assign w_is_div = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);
    assign w_div0   = w_is_div && (B == 32'd0);
    assign w_go     = Start && !Flush && !Busy && w_arith;
    assign w_mthi   = Start && !Flush && !Busy && (MDUOp == OP_MTHI);
    assign w_mtlo   = Start && !Flush && !Busy && (MDUOp == OP_MTLO);

    assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    always_comb begin
        w_result = 64'd0;
        case (MDUOp)
            OP_MULT:  w_result = w_prod_s;
            OP_MULTU: w_result = w_prod_u;
            OP_DIV:   w_result = div_signed(A, B);
            OP_DIVU:  w_result = div_unsigned(A, B);
            default:  w_result = 64'd0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_go) w_next_state = RUN;
            RUN:     if (r_cnt <= 8'd1) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Launch latches operands' result; commit to HI/LO on the last busy cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_phi   <= 32'd0;
            r_plo   <= 32'd0;
            r_pwr   <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (w_go) begin
                r_phi <= w_result[63:32];
                r_plo <= w_result[31:0];
                r_pwr <= !w_div0;
                r_cnt <= w_is_div ? DIV_N : MULT_N;
            end else if (r_state == RUN) begin
                r_cnt <= r_cnt - 8'd1;
                if ((r_cnt <= 8'd1) && r_pwr) begin
                    r_hi <= r_phi;
                    r_lo <= r_plo;
                end
            end
            if (w_mthi) r_hi <= A;
            if (w_mtlo) r_lo <= A;
        end
    end

    assign Busy   = (r_state == RUN);
    assign Stall  = (D_MDUOp >= OP_MULT) && (D_MDUOp <= OP_MTLO) && (Busy || w_go);
    assign HI     = r_hi;
    assign LO     = r_lo;
    assign MDUOut = (MDUOp == OP_MFHI) ? r_hi :
                    (MDUOp == OP_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with hand-computed HI/LO, Busy and Stall values.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        Start;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  D_MDUOp;
    logic        Flush;
    logic        Busy;
    logic        Stall;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUOut;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .Start   (Start),
        .MDUOp   (MDUOp),
        .A       (A),
        .B       (B),
        .D_MDUOp (D_MDUOp),
        .Flush   (Flush),
        .Busy    (Busy),
        .Stall   (Stall),
        .HI      (HI),
        .LO      (LO),
        .MDUOut  (MDUOut)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        MDUOp = op;
        A     = a;
        B     = b;
        #1;
    endtask

    // Drop Start and scramble operands so late operand changes are exercised
    task automatic clear();
        Start = 1'b0;
        MDUOp = 4'd0;
        A     = 32'hA5A5A5A5;
        B     = 32'h5A5A5A5A;
        #1;
    endtask

    task automatic busy_run(input int n, input logic exp_stall, input string tag);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_busy"}, {31'd0, Busy}, 32'd1);
            chk({tag, "_stall"}, {31'd0, Stall}, {31'd0, exp_stall});
            tick();
        end
    endtask

    initial begin
        reset_n = 1'b0;
        Start   = 1'b0;
        MDUOp   = 4'd0;
        A       = 32'd0;
        B       = 32'd0;
        D_MDUOp = 4'd0;
        Flush   = 1'b0;
        tick();
        tick();
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_stall", {31'd0, Stall}, 32'd0);
        reset_n = 1'b1;
        tick();

        // mult -2 * 3 with an MDU op waiting in Decode
        D_MDUOp = 4'd5;
        launch(4'd1, 32'hFFFFFFFE, 32'd3);
        chk("mult_go_stall", {31'd0, Stall}, 32'd1);
        chk("mult_go_busy", {31'd0, Busy}, 32'd0);
        tick();
        clear();
        busy_run(5, 1'b1, "mult");
        chk("mult_end_busy", {31'd0, Busy}, 32'd0);
        chk("mult_end_stall", {31'd0, Stall}, 32'd0);
        chk("mult_hi", HI, 32'hFFFFFFFF);
        chk("mult_lo", LO, 32'hFFFFFFFA);
        D_MDUOp = 4'd0;

        // multu, non-MDU instruction in Decode never stalls
        launch(4'd2, 32'hFFFFFFFF, 32'd2);
        chk("multu_go_stall", {31'd0, Stall}, 32'd0);
        tick();
        clear();
        busy_run(5, 1'b0, "multu");
        chk("multu_end_busy", {31'd0, Busy}, 32'd0);
        chk("multu_hi", HI, 32'h00000001);
        chk("multu_lo", LO, 32'hFFFFFFFE);

        // div -7 / 2
        launch(4'd3, 32'hFFFFFFF9, 32'd2);
        tick();
        clear();
        busy_run(10, 1'b0, "div");
        chk("div_end_busy", {31'd0, Busy}, 32'd0);
        chk("div_hi", HI, 32'hFFFFFFFF);
        chk("div_lo", LO, 32'hFFFFFFFD);

        // div overflow case
        launch(4'd3, 32'h80000000, 32'hFFFFFFFF);
        tick();
        clear();
        busy_run(10, 1'b0, "divov");
        chk("divov_hi", HI, 32'h00000000);
        chk("divov_lo", LO, 32'h80000000);

        // mthi/mtlo then divu by zero leaves HI/LO alone
        launch(4'd7, 32'h00000011, 32'd0);
        tick();
        launch(4'd8, 32'h00000022, 32'd0);
        tick();
        chk("mt_hi", HI, 32'h00000011);
        chk("mt_lo", LO, 32'h00000022);
        launch(4'd4, 32'd5, 32'd0);
        tick();
        clear();
        busy_run(10, 1'b0, "divu0");
        chk("divu0_end_busy", {31'd0, Busy}, 32'd0);
        chk("divu0_hi", HI, 32'h00000011);
        chk("divu0_lo", LO, 32'h00000022);

        // mthi then mfhi the next cycle, no stall
        D_MDUOp = 4'd5;
        launch(4'd7, 32'hDEADBEEF, 32'd0);
        chk("mthi_stall", {31'd0, Stall}, 32'd0);
        tick();
        launch(4'd5, 32'd0, 32'd0);
        chk("mfhi_out", MDUOut, 32'hDEADBEEF);
        chk("mfhi_stall", {31'd0, Stall}, 32'd0);
        chk("mfhi_busy", {31'd0, Busy}, 32'd0);
        MDUOp = 4'd6;
        #1;
        chk("mflo_out", MDUOut, 32'h00000022);
        MDUOp = 4'd0;
        #1;
        chk("mdu_none_out", MDUOut, 32'd0);
        tick();
        clear();
        D_MDUOp = 4'd0;

        // flushed mult does nothing
        Flush = 1'b1;
        launch(4'd1, 32'd3, 32'd3);
        tick();
        clear();
        Flush = 1'b0;
        chk("flush_busy", {31'd0, Busy}, 32'd0);
        tick();
        chk("flush_busy2", {31'd0, Busy}, 32'd0);
        chk("flush_hi", HI, 32'hDEADBEEF);
        chk("flush_lo", LO, 32'h00000022);

        // mult 2*3, second mult and a flush arrive while busy and are ignored
        launch(4'd1, 32'd2, 32'd3);
        tick();
        clear();
        chk("ign_busy1", {31'd0, Busy}, 32'd1);
        tick();
        launch(4'd1, 32'd100, 32'd100);
        chk("ign_busy2", {31'd0, Busy}, 32'd1);
        tick();
        clear();
        Flush = 1'b1;
        #1;
        chk("ign_busy3", {31'd0, Busy}, 32'd1);
        tick();
        Flush = 1'b0;
        busy_run(2, 1'b0, "ign");
        chk("ign_end_busy", {31'd0, Busy}, 32'd0);
        chk("ign_hi", HI, 32'd0);
        chk("ign_lo", LO, 32'd6);

        // back-to-back launch in the cycle Busy falls
        launch(4'd2, 32'd4, 32'd5);
        tick();
        clear();
        busy_run(5, 1'b0, "b2b");
        chk("b2b_end_busy", {31'd0, Busy}, 32'd0);
        chk("b2b_lo", LO, 32'd20);
        chk("b2b_hi", HI, 32'd0);

        // reset in the third busy cycle of a div aborts it
        launch(4'd3, 32'd100, 32'd7);
        tick();
        clear();
        tick();
        tick();
        chk("rstmid_busy_pre", {31'd0, Busy}, 32'd1);
        reset_n = 1'b0;
        tick();
        chk("rstmid_busy", {31'd0, Busy}, 32'd0);
        chk("rstmid_hi", HI, 32'd0);
        chk("rstmid_lo", LO, 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("rstmid_busy_after", {31'd0, Busy}, 32'd0);
        chk("rstmid_lo_after", LO, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
